// File: rtl/dino_regs_pkg.sv
// dino_regs_pkg
//   Shared constants for the dino sprite/score register bank.
//   - Avalon word addresses of the CTRL and STATUS registers
//   - bit positions inside CTRL and STATUS
//   - index of every sprite/score register in the shadow/live arrays
//   - status_word(): packs the STATUS read value
package dino_regs_pkg;

  localparam logic [8:0] ADDR_CTRL   = 9'h100;
  localparam logic [8:0] ADDR_STATUS = 9'h101;

  localparam int CTRL_COMMIT_EN     = 0;
  localparam int CTRL_FORCE_COMMIT  = 1;
  localparam int STATUS_IRQ_PENDING = 0;
  localparam int STATUS_FC_LSB      = 16;

  localparam int DINO_X    = 0;
  localparam int DINO_Y    = 1;
  localparam int CACTUS0_X = 2;
  localparam int CACTUS0_Y = 3;
  localparam int CACTUS1_X = 4;
  localparam int CACTUS1_Y = 5;
  localparam int PTERO_X   = 6;
  localparam int PTERO_Y   = 7;
  localparam int GROUND_X  = 8;
  localparam int CLOUD_X   = 9;
  localparam int CLOUD_Y   = 10;
  localparam int SCORE_X   = 11;
  localparam int SCORE_Y   = 12;

  function automatic logic [31:0] status_word(input logic [15:0] fc, input logic irq_pend);
    return {fc, 15'd0, irq_pend};
  endfunction

endpackage

// File: rtl/dino_reg_shadow_if.sv
// dino_reg_shadow_if
//   Avalon-MM slave bus between the HPS bridge and the register bank.
//   chipselect/write/read : transfer qualifiers
//   address[8:0]          : word address
//   writedata[31:0]       : write data
//   readdata[31:0]        : registered read data (driven by the slave)
interface dino_reg_shadow_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/dino_frame_ticker.sv
// dino_frame_ticker
//   Detects the falling edge of the active-low vertical sync and derives the
//   frame-locked counters from it.
//   clk, reset   : clock, asynchronous active-high reset
//   vga_vs       : active-low vertical sync
//   frame_evt    : one-cycle pulse, high in the cycle vga_vs is first seen low
//   frame_count  : frames since reset, wraps at 16 bits
//   anim_phase   : advances once every ANIM_DIV frames, modulo ANIM_STATES
module dino_frame_ticker #(
  parameter int ANIM_DIV    = 6,
  parameter int ANIM_STATES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_vs,
  output logic        frame_evt,
  output logic [15:0] frame_count,
  output logic [1:0]  anim_phase
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic             r_vs_d;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_frame_count;
  logic [1:0]       r_phase;
  logic             w_frame_evt;
  logic             w_div_tc;

  // Previous vs resets high so a low vga_vs at release is not a false edge.
  assign w_frame_evt = r_vs_d & ~vga_vs;
  assign w_div_tc    = (r_div == DIV_W'(ANIM_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_d        <= 1'b1;
      r_div         <= '0;
      r_frame_count <= '0;
      r_phase       <= '0;
    end else begin
      r_vs_d <= vga_vs;
      if (w_frame_evt) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (w_div_tc) begin
          r_div   <= '0;
          r_phase <= (r_phase == 2'(ANIM_STATES - 1)) ? 2'd0 : r_phase + 2'd1;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  assign frame_evt   = w_frame_evt;
  assign frame_count = r_frame_count;
  assign anim_phase  = r_phase;

endmodule

// File: rtl/dino_reg_shadow.sv
// dino_reg_shadow
//   Double-buffered sprite/score register bank. Software writes land in
//   shadow registers; all shadows are copied into the live registers on the
//   vertical-sync falling edge (when commit_en is set) or on a force_commit
//   write, so the renderer never sees a half-updated frame.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : Avalon-MM slave (dino_reg_shadow_if.slave)
//   vga_vs       : active-low vertical sync
//   live_regs    : committed registers, reg i at [i*REG_W +: REG_W]
//   frame_count  : frames since reset
//   anim_phase   : frame-locked animation phase
//   irq          : vblank interrupt, level, active-high
//   Build option: define VBLANK_IRQ_EN to include the vblank interrupt;
//   otherwise irq is tied low and STATUS bit0 reads 0.
module dino_reg_shadow
  import dino_regs_pkg::*;
#(
  parameter int NUM_REGS    = 13,
  parameter int REG_W       = 10,
  parameter int ANIM_DIV    = 6,
  parameter int ANIM_STATES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  dino_reg_shadow_if.slave          bus,
  input  logic                      vga_vs,
  output logic [NUM_REGS*REG_W-1:0] live_regs,
  output logic [15:0]               frame_count,
  output logic [1:0]                anim_phase,
  output logic                      irq
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [REG_W-1:0] r_shadow [NUM_REGS];
  logic [REG_W-1:0] r_live   [NUM_REGS];
  logic             r_commit_en;
  logic [31:0]      r_readdata;

  logic             w_frame_evt;
  logic [15:0]      w_frame_count;
  logic             w_wr;
  logic             w_rd;
  logic             w_is_shadow;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr_shadow;
  logic             w_wr_ctrl;
  logic             w_wr_status;
  logic             w_commit;
  logic             w_irq_bit;
  logic [31:0]      w_rd_mux;

  dino_frame_ticker #(
    .ANIM_DIV    (ANIM_DIV),
    .ANIM_STATES (ANIM_STATES)
  ) u_ticker (
    .clk         (clk),
    .reset       (reset),
    .vga_vs      (vga_vs),
    .frame_evt   (w_frame_evt),
    .frame_count (w_frame_count),
    .anim_phase  (anim_phase)
  );

  assign w_wr        = bus.chipselect & bus.write;
  assign w_rd        = bus.chipselect & bus.read;
  assign w_is_shadow = (bus.address < 9'(NUM_REGS));
  assign w_idx       = bus.address[IDX_W-1:0];
  assign w_wr_shadow = w_wr & w_is_shadow;
  assign w_wr_ctrl   = w_wr & (bus.address == ADDR_CTRL);
  assign w_wr_status = w_wr & (bus.address == ADDR_STATUS);

  // Commit gating uses the commit_en value held before this cycle's write.
  assign w_commit = (w_frame_evt & r_commit_en) |
                    (w_wr_ctrl & bus.writedata[CTRL_FORCE_COMMIT]);

  always_comb begin
    w_rd_mux = '0;
    if (w_is_shadow) begin
      w_rd_mux = 32'(r_shadow[w_idx]);
    end else if (bus.address == ADDR_CTRL) begin
      w_rd_mux[CTRL_COMMIT_EN] = r_commit_en;
    end else if (bus.address == ADDR_STATUS) begin
      w_rd_mux = status_word(w_frame_count, w_irq_bit);
    end
  end

  // Non-blocking copy means a shadow write in the commit cycle is not
  // captured by that commit; it goes out with the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
      r_commit_en <= 1'b1;
      r_readdata  <= '0;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) r_live[i] <= r_shadow[i];
      end
      if (w_wr_shadow) r_shadow[w_idx] <= bus.writedata[REG_W-1:0];
      if (w_wr_ctrl)   r_commit_en     <= bus.writedata[CTRL_COMMIT_EN];
      if (w_rd)        r_readdata      <= w_rd_mux;
    end
  end

`ifdef VBLANK_IRQ_EN
  logic r_irq_pending;

  // A frame event in the same cycle as a clear keeps the interrupt pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_pending <= 1'b0;
    end else if (w_frame_evt) begin
      r_irq_pending <= 1'b1;
    end else if (w_wr_status & bus.writedata[STATUS_IRQ_PENDING]) begin
      r_irq_pending <= 1'b0;
    end
  end

  assign w_irq_bit = r_irq_pending;
`else
  assign w_irq_bit = 1'b0;
`endif

  assign irq = w_irq_bit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_live
    assign live_regs[gi*REG_W +: REG_W] = r_live[gi];
  end

  assign bus.readdata = r_readdata;
  assign frame_count  = w_frame_count;

endmodule

// File: tb/tb_dino_reg_shadow.sv
module tb_dino_reg_shadow;
  import dino_regs_pkg::*;

  localparam int NUM_REGS    = 13;
  localparam int REG_W       = 10;
  localparam int ANIM_DIV    = 6;
  localparam int ANIM_STATES = 3;
`ifdef VBLANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic vga_vs;
  wire [NUM_REGS*REG_W-1:0] live_regs;
  wire [15:0] frame_count;
  wire [1:0]  anim_phase;
  wire        irq;

  dino_reg_shadow_if bus ();

  dino_reg_shadow #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .ANIM_DIV(ANIM_DIV), .ANIM_STATES(ANIM_STATES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .vga_vs(vga_vs),
    .live_regs(live_regs), .frame_count(frame_count),
    .anim_phase(anim_phase), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame-level view of the register bank.
  logic [REG_W-1:0] m_sh [NUM_REGS];
  logic [REG_W-1:0] m_lv [NUM_REGS];
  int               m_frames;
  bit               m_commit_en;
  bit               m_irq;
  logic [31:0]      m_rd;
  bit               m_vs_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REG_W-1:0] live(input int i);
    return live_regs[i*REG_W +: REG_W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin m_sh[i] = '0; m_lv[i] = '0; end
    m_frames = 0; m_commit_en = 1'b1; m_irq = 1'b0; m_rd = '0; m_vs_prev = 1'b1;
  endtask

  // Apply the rules for one clock edge given the inputs currently driven.
  task automatic model_step();
    bit evt, wr, rd, commit;
    int a;
    evt = m_vs_prev && !vga_vs;
    wr  = bus.chipselect && bus.write;
    rd  = bus.chipselect && bus.read;
    a   = int'(bus.address);
    commit = (evt && m_commit_en) || (wr && a == 'h100 && bus.writedata[1]);
    if (rd) begin
      if (a < NUM_REGS)   m_rd = 32'(m_sh[a]);
      else if (a == 'h100) m_rd = {31'd0, m_commit_en};
      else if (a == 'h101) m_rd = {16'(m_frames), 15'd0, m_irq};
      else                 m_rd = 32'd0;
    end
    if (commit) for (int i = 0; i < NUM_REGS; i++) m_lv[i] = m_sh[i];
    if (wr && a < NUM_REGS) m_sh[a] = bus.writedata[REG_W-1:0];
    if (wr && a == 'h100)   m_commit_en = bus.writedata[0];
    if (IRQ_ON) begin
      if (evt) m_irq = 1'b1;
      else if (wr && a == 'h101 && bus.writedata[0]) m_irq = 1'b0;
    end
    if (evt) m_frames++;
    m_vs_prev = vga_vs;
  endtask

  task automatic check_state();
    check("readdata", bus.readdata, m_rd);
    check("frame_count", 32'(frame_count), 32'(16'(m_frames)));
    check("anim_phase", 32'(anim_phase), 32'((m_frames / ANIM_DIV) % ANIM_STATES));
    check("irq", 32'(irq), 32'(m_irq));
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("live%0d", i), 32'(live(i)), 32'(m_lv[i]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic idle();
    bus.chipselect = 0; bus.write = 0; bus.read = 0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write = 1; bus.read = 0; bus.address = a; bus.writedata = d;
    tick(); idle();
  endtask

  task automatic rd(input logic [8:0] a);
    bus.chipselect = 1; bus.write = 0; bus.read = 1; bus.address = a;
    tick(); idle();
  endtask

  task automatic frame();
    vga_vs = 0; tick(); vga_vs = 1; tick(); tick();
  endtask

  task automatic do_reset();
    idle(); vga_vs = 1;
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
    check_state();
  endtask

  initial begin
    int fc0;
    logic [8:0] ra;
    idle(); bus.address = '0; bus.writedata = '0;
    vga_vs = 1; reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check_state();

    // Shadow write stays hidden until the frame edge.
    wr(9'(DINO_X), 32'd100);
    tick();
    check("t1_live0_before", 32'(live(0)), 32'd0);
    rd(9'd0);
    check("t1_read0", bus.readdata, 32'd100);
    vga_vs = 0; tick();
    check("t1_live0_after", 32'(live(0)), 32'd100);
    vga_vs = 1; tick();

    // commit_en=0 freezes live; force_commit pushes it out.
    do_reset();
    wr(ADDR_CTRL, 32'd0);
    wr(9'(PTERO_X), 32'd500);
    repeat (3) frame();
    check("t2_live6_frozen", 32'(live(6)), 32'd0);
    check("t2_fc3", 32'(frame_count), 32'd3);
    wr(ADDR_CTRL, 32'd2);
    check("t2_live6_forced", 32'(live(6)), 32'd500);
    wr(ADDR_CTRL, 32'd1);

    // Shadow write in the frame_evt cycle commits one frame later.
    wr(9'(DINO_Y), 32'd30);
    frame();
    bus.chipselect = 1; bus.write = 1; bus.address = 9'(DINO_Y); bus.writedata = 32'd50;
    vga_vs = 0; tick(); idle();
    check("t3_live1_old", 32'(live(1)), 32'd30);
    vga_vs = 1; tick();
    frame();
    check("t3_live1_new", 32'(live(1)), 32'd50);

    // Interrupt set, clear, and set-wins-over-clear.
    frame();
    check("t4_irq_set", 32'(irq), 32'(IRQ_ON));
    wr(ADDR_STATUS, 32'd1);
    check("t4_irq_clr", 32'(irq), 32'd0);
    bus.chipselect = 1; bus.write = 1; bus.address = ADDR_STATUS; bus.writedata = 32'd1;
    vga_vs = 0; tick(); idle();
    check("t4_irq_setwins", 32'(irq), 32'(IRQ_ON));
    vga_vs = 1; tick();

    // force_commit coincident with frame_evt.
    wr(9'(CACTUS0_X), 32'd7);
    bus.chipselect = 1; bus.write = 1; bus.address = ADDR_CTRL; bus.writedata = 32'd3;
    vga_vs = 0; tick(); idle();
    check("t5_live2", 32'(live(2)), 32'd7);
    vga_vs = 1; tick();

    // vga_vs held low: exactly one event.
    fc0 = int'(frame_count);
    vga_vs = 0; repeat (8) tick(); vga_vs = 1; tick();
    check("t6_one_evt", 32'(frame_count), 32'(fc0 + 1));

    // Animation phase over 18 frames.
    do_reset();
    for (int f = 1; f <= 18; f++) begin
      frame();
      if (f == 5)  check("t7_phase_f5", 32'(anim_phase), 32'd0);
      if (f == 6)  check("t7_phase_f6", 32'(anim_phase), 32'd1);
      if (f == 12) check("t7_phase_f12", 32'(anim_phase), 32'd2);
      if (f == 18) check("t7_phase_f18", 32'(anim_phase), 32'd0);
    end
    rd(ADDR_STATUS);
    check("t7_status_fc", 32'(bus.readdata[31:16]), 32'd18);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    ra = 9'($urandom_range(0, 15));
        2:       ra = ($urandom_range(0, 1) != 0) ? ADDR_CTRL : ADDR_STATUS;
        default: ra = 9'($urandom_range(0, 511));
      endcase
      bus.address   = ra;
      bus.writedata = $urandom();
      case ($urandom_range(0, 3))
        0: begin bus.chipselect = 1; bus.write = 1; bus.read = 0; end
        1: begin bus.chipselect = 1; bus.write = 0; bus.read = 1; end
        2: begin bus.chipselect = 0; bus.write = 1; bus.read = 1; end
        default: idle();
      endcase
      if ($urandom_range(0, 5) == 0) vga_vs = ~vga_vs;
      tick();
    end
    idle(); vga_vs = 1; tick();

    // Reset mid-frame with nonzero live registers.
    wr(ADDR_CTRL, 32'd3);
    wr(9'(DINO_X), 32'h3FF);
    wr(ADDR_CTRL, 32'd3);
    check("t9_live0_set", 32'(live(0)), 32'h3FF);
    vga_vs = 0; tick();
    #2 reset = 1;
    #1;
    check("t9_rst_live", 32'(live_regs == '0), 32'd1);
    check("t9_rst_fc", 32'(frame_count), 32'd0);
    check("t9_rst_phase", 32'(anim_phase), 32'd0);
    check("t9_rst_irq", 32'(irq), 32'd0);
    check("t9_rst_rd", bus.readdata, 32'd0);
    vga_vs = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
    check_state();
    rd(ADDR_CTRL);
    check("t9_commit_en", bus.readdata, 32'd1);
    frame();
    check("t9_first_frame", 32'(frame_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dino_reg_shadow.md
# dino_reg_shadow

Double-buffered sprite/score register bank between the HPS Avalon-MM bus and the VGA sprite renderer. Software writes land in shadow registers; all shadows are copied into live registers at the start of vertical sync, so the renderer never sees a half-updated frame. The block also provides a frame counter, a frame-locked animation phase for dino/pterodactyl leg/wing cycling (replacing free-running cycle counters), and an optional vblank interrupt.

## Interface
Parameters:
- NUM_REGS, 13: number of sprite/score registers (addresses 0..NUM_REGS-1).
- REG_W, 10: width of each register; writedata[REG_W-1:0] is stored.
- ANIM_DIV, 6: frames per animation-phase step (≥1).
- ANIM_STATES, 3: animation phase modulus (2..4).

Ports:
- clk  in  1  system clock, same domain as the VGA counters. Already decided.
- reset  in  1  asynchronous, active-high. Already decided.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  9  Avalon word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data.
- vga_vs  in  1  active-low vertical sync from the VGA counters.
- live_regs  out  NUM_REGS*REG_W  committed registers, reg i at [i*REG_W +: REG_W].
- frame_count  out  16  frames since reset, wraps.
- anim_phase  out  2  animation phase, 0..ANIM_STATES-1.
- irq  out  1  vblank interrupt, level, active-high.

## Operation
- Address map: 0..NUM_REGS-1 shadow regs (R/W); 0x100 CTRL (R/W): bit0 commit_en (reset 1), bit1 force_commit (write-only, self-clearing, reads 0); 0x101 STATUS (R): bit0 irq_pending, bits[31:16] frame_count; write bit0=1 clears irq_pending. Other addresses: writes ignored, reads 0.
- Write to a shadow address: shadow[address] <= writedata[REG_W-1:0]. Live unaffected until commit.
- Frame event: vs_d <= vga_vs each cycle; frame_evt = vs_d & ~vga_vs (falling edge).
- Commit: on frame_evt with commit_en=1, or on force_commit write, live[i] <= shadow[i] for all i. commit_en=0 freezes live across frames (software batch update).
- On frame_evt (regardless of commit_en): frame_count += 1 (wrap 0xFFFF→0); anim divider counts 0..ANIM_DIV-1; on terminal count anim_phase <= (anim_phase==ANIM_STATES-1) ? 0 : anim_phase+1; irq_pending <= 1.
- irq = irq_pending.
- Reset: all shadow and live regs 0, readdata 0, frame_count 0, anim_phase 0, divider 0, irq_pending 0, commit_en 1, vs_d 1.

## Timing
- Writes: 1 cycle; shadow visible to reads on the next cycle.
- Reads: readdata valid one cycle after chipselect&read; holds value otherwise.
- Commit: live_regs update on the clock edge following the cycle frame_evt is high (1-cycle latency from vga_vs falling).
- Simultaneous shadow write and commit in the same cycle: commit copies the OLD shadow; new value is committed at the next frame.
- Simultaneous frame_evt and STATUS clear write: set wins, irq_pending stays 1.
- Simultaneous force_commit and frame_evt: single commit, identical result.
- vga_vs held low across many cycles: exactly one frame_evt per falling edge.
- Reset asserted mid-frame: all state returns to reset values immediately; first frame_evt after release counts as frame 1.

## Configuration
- VBLANK_IRQ_EN defined: irq_pending, STATUS bit0 and irq behave as above.
- Not defined: no irq_pending flop; irq tied 0; STATUS bit0 reads 0; clear writes ignored. Commit, frame_count, anim_phase unchanged.

## Structure
- Package dino_regs_pkg: ADDR_CTRL (9'h100), ADDR_STATUS (9'h101), CTRL/STATUS bit-index constants, sprite register index constants (DINO_X=0 … SCORE_Y=12).
- Sub-module dino_frame_ticker: vs edge detect, frame_count, anim divider and anim_phase; outputs frame_evt. Top holds bus decode, shadow/live arrays, irq.

## Test plan
- Write shadow[0]=100, no vs edge → live reg0 stays 0, read addr 0 returns 100; after one vga_vs falling edge → live reg0=100 next cycle.
- CTRL commit_en=0, write shadow[6]=500, three frames → live reg6=0, frame_count=3; write CTRL force_commit → live reg6=500 next cycle.
- Write shadow[1]=50 in exact frame_evt cycle → live reg1 keeps old value; after next frame → 50.
- ANIM_DIV=6, ANIM_STATES=3: 18 frames → anim_phase sequence 0,1,2,0 at frames 6,12,18; frame_count=18 in STATUS[31:16].
- VBLANK_IRQ_EN: frame → irq=1; write STATUS=1 → irq=0; clear coincident with frame_evt → irq stays 1. Without macro → irq always 0.
- Assert reset mid-frame with live regs nonzero → all outputs 0, anim_phase 0, commit_en reads 1.
